// File: rtl/seg_disp_ctrl.sv
// Two-requester seven-segment display controller: round-robin valid/ready intake,
// minimum hold time, scanned anode/segment drive. Optional macro: SEG_BLANK_LZ_EN.
module seg_disp_ctrl #(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned HOLD_MIN = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic [31:0] req0_data,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [31:0] req1_data,
  output logic        req1_ready,
  output logic [7:0]  an,
  output logic [7:0]  seg,
  output logic        cur_src,
  output logic        busy
);

  localparam int unsigned PSC_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_MIN > 1) ? $clog2(HOLD_MIN) : 1;
  localparam logic [PSC_W-1:0]  PSC_LAST  = PSC_W'(SCAN_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_MIN - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t              r_state;
  logic                r_last_grant;
  logic [31:0]         r_disp;
  logic [HOLD_W-1:0]   r_hold_cnt;
  logic [PSC_W-1:0]    r_psc;
  logic [2:0]          r_digit;

  logic                w_gnt_vld;
  logic                w_gnt_idx;
  logic [31:0]         w_gnt_data;
  logic [3:0]          w_nibble;
  logic [6:0]          w_glyph;
  logic                w_dp_n;
  logic                w_blank;
  logic [7:0]          w_seg_nxt;

  // Arbitration: only in IDLE; on contention the requester not granted last wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 1'b0;
    if (r_state == ST_IDLE) begin
      if (req0_valid && req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = ~r_last_grant;
      end else if (req0_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 1'b0;
      end else if (req1_valid) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = 1'b1;
      end
    end
  end

  assign req0_ready = w_gnt_vld & ~w_gnt_idx;
  assign req1_ready = w_gnt_vld &  w_gnt_idx;
  assign w_gnt_data = w_gnt_idx ? req1_data : req0_data;

  // Handshake / hold FSM; a grant in IDLE is always a transfer since grant implies valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_disp       <= 32'd0;
      r_hold_cnt   <= '0;
      cur_src      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_gnt_vld) begin
            r_disp       <= w_gnt_data;
            cur_src      <= w_gnt_idx;
            r_last_grant <= w_gnt_idx;
            r_hold_cnt   <= HOLD_LOAD;
            r_state      <= ST_HOLD;
            busy         <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (r_hold_cnt == '0) begin
            r_state <= ST_IDLE;
            busy    <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

  // Free-running digit scan, independent of the handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc   <= '0;
      r_digit <= 3'd0;
    end else begin
      if (r_psc == PSC_LAST) begin
        r_psc   <= '0;
        r_digit <= r_digit + 3'd1;
      end else begin
        r_psc <= r_psc + PSC_W'(1);
      end
    end
  end

  assign w_nibble = r_disp[{r_digit, 2'b00} +: 4];
  assign w_dp_n   = ~((r_digit == 3'd0) && cur_src);

  // Active-low hex glyph, bit order g..a.
  always_comb begin
    w_glyph = 7'h7F;
    case (w_nibble)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

`ifdef SEG_BLANK_LZ_EN
  // A digit is a leading zero when it and every nibble above it are zero; digit 0 always shows.
  assign w_blank = (r_digit != 3'd0) && ((r_disp >> {r_digit, 2'b00}) == 32'd0);
`else
  assign w_blank = 1'b0;
`endif

  assign w_seg_nxt = w_blank ? 8'hFF : {w_dp_n, w_glyph};

  // an and seg share one register stage so they always switch on the same edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'(1) << r_digit);
      seg <= w_seg_nxt;
    end
  end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Self-checking bench for seg_disp_ctrl: directed scenarios plus random traffic
// against a cycle-count based reference model.
module tb_seg_disp_ctrl;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned HOLD_MIN = 8;

  logic        clk;
  logic        rst;
  logic        req0_valid;
  logic [31:0] req0_data;
  logic        req0_ready;
  logic        req1_valid;
  logic [31:0] req1_data;
  logic        req1_ready;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        cur_src;
  logic        busy;

  seg_disp_ctrl #(.SCAN_DIV(SCAN_DIV), .HOLD_MIN(HOLD_MIN)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .an         (an),
    .seg        (seg),
    .cur_src    (cur_src),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: edges since reset release, displayed word/source,
  // last grant, and the last edge index after which the block is still holding.
  int          m_n;
  logic [31:0] m_disp;
  logic        m_src;
  logic        m_last;
  int          m_hold_end;

  logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_seg(input int dig, input logic [31:0] val, input logic src);
    logic [7:0] s;
    int hi;
    s = glyph_tab[(val >> (4 * dig)) & 32'hF];
    if (dig == 0 && src) s[7] = 1'b0;
    hi = 0;
    for (int i = 0; i < 8; i++)
      if (((val >> (4 * i)) & 32'hF) != 0) hi = i;
`ifdef SEG_BLANK_LZ_EN
    if (dig > hi) s = 8'hFF;
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_n        = 0;
    m_disp     = 32'd0;
    m_src      = 1'b0;
    m_last     = 1'b1;
    m_hold_end = -1;
  endtask

  // One clock: drive inputs, check ready before the edge, check registered outputs after it.
  task automatic step(input logic v0, input logic [31:0] d0, input logic v1, input logic [31:0] d1);
    int          e;
    int          dig;
    logic        idle;
    logic        g_vld;
    logic        g;
    logic [31:0] pd;
    logic        ps;
    logic [7:0]  a_exp;
    req0_valid = v0;
    req0_data  = d0;
    req1_valid = v1;
    req1_data  = d1;
    #1;
    e     = m_n + 1;
    idle  = (e - 1) > m_hold_end;
    g_vld = 1'b0;
    g     = 1'b0;
    if (idle) begin
      if (v0 && v1) begin g_vld = 1'b1; g = ~m_last; end
      else if (v0)  begin g_vld = 1'b1; g = 1'b0; end
      else if (v1)  begin g_vld = 1'b1; g = 1'b1; end
    end
    chk("req0_ready", 32'(req0_ready), 32'(g_vld && !g));
    chk("req1_ready", 32'(req1_ready), 32'(g_vld && g));
    @(posedge clk);
    #1;
    pd = m_disp;
    ps = m_src;
    if (g_vld) begin
      m_disp     = g ? d1 : d0;
      m_src      = g;
      m_last     = g;
      m_hold_end = e + int'(HOLD_MIN) - 1;
    end
    m_n   = e;
    dig   = ((e - 1) / int'(SCAN_DIV)) % 8;
    a_exp = ~(8'(1) << dig);
    chk("busy", 32'(busy), 32'(e <= m_hold_end));
    chk("cur_src", 32'(cur_src), 32'(m_src));
    chk("an", 32'(an), 32'(a_exp));
    chk("seg", 32'(seg), 32'(exp_seg(dig, pd, ps)));
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 1'b0, 32'd0);
  endtask

  initial begin
    logic [31:0] d0;
    logic [31:0] d1;
    rst        = 1'b0;
    req0_valid = 1'b0;
    req0_data  = 32'd0;
    req1_valid = 1'b0;
    req1_data  = 32'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_an", 32'(an), 32'hFF);
    chk("rst_seg", 32'(seg), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cur_src", 32'(cur_src), 32'd0);
    chk("rst_ready0", 32'(req0_ready), 32'd0);
    chk("rst_ready1", 32'(req1_ready), 32'd0);
    rst = 1'b1;

    // Scan with no requests across more than one full frame
    idle_steps(40);

    // Single req0 transfer of 0x18, then watch the hold and a full frame
    step(1'b1, 32'h0000_0018, 1'b0, 32'd0);
    idle_steps(40);

    // Continuous contention: grants alternate, transfers HOLD_MIN+1 apart
    for (int i = 0; i < 40; i++) step(1'b1, $urandom, 1'b1, $urandom);
    idle_steps(12);

    // req1 arrives during HOLD and waits for IDLE
    step(1'b1, 32'h1234_5678, 1'b0, 32'd0);
    for (int i = 0; i < 15; i++) step(1'b0, 32'd0, 1'b1, 32'h8765_4321);
    idle_steps(12);

    // Reset three cycles into HOLD
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 32'd0);
    idle_steps(3);
    rst = 1'b0;
    #1;
    chk("midrst_an", 32'(an), 32'hFF);
    chk("midrst_seg", 32'(seg), 32'hFF);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_cur_src", 32'(cur_src), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    model_reset();
    step(1'b0, 32'd0, 1'b1, 32'h0000_00C5);
    idle_steps(12);

    // All-A word on every digit
    step(1'b1, 32'hAAAA_AAAA, 1'b0, 32'd0);
    idle_steps(40);

    // Random traffic, with data shifted to exercise leading zeros
    for (int i = 0; i < 400; i++) begin
      d0 = $urandom >> $urandom_range(0, 31);
      d1 = $urandom >> $urandom_range(0, 31);
      step(1'($urandom_range(0, 2) == 0), d0, 1'($urandom_range(0, 2) == 0), d1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_disp_ctrl.md
# seg_disp_ctrl

Display controller that shares the board's eight seven-segment digits between two requesters (req0: CPU instruction word, req1: debug/PC word) and time-multiplexes the latched 32-bit value onto a single scanned segment bus. It sits between the CPU and the seven-segment pins at the top level. It arbitrates round-robin with a valid/ready handshake and enforces a minimum on-screen hold time. It replaces the static eight-bus segment decode with a scanned anode/segment drive.

## Interface
Parameters:
- SCAN_DIV, 1000: clock cycles each digit stays selected (≥2).
- HOLD_MIN, 4096: minimum cycles an accepted value is displayed before a new one may be accepted (≥1).

Ports:
- clk  input  1  clock; all state on rising edge.
- rst  input  1  reset; asynchronous, active-low.
- req0_valid  input  1  requester 0 offers req0_data.
- req0_data  input  32  requester 0 display word.
- req0_ready  output  1  requester 0 transfer accepted this cycle.
- req1_valid  input  1  requester 1 offers req1_data.
- req1_data  input  32  requester 1 display word.
- req1_ready  output  1  requester 1 transfer accepted this cycle.
- an  output  8  digit enables, active-low, one-hot-low; an[i] selects digit i.
- seg  output  8  segments, active-low; seg[6:0] = g..a, seg[7] = decimal point.
- cur_src  output  1  source of the displayed word (0 = req0, 1 = req1).
- busy  output  1  high while in HOLD.

## Operation
- FSM has two states, IDLE and HOLD.
- IDLE:
  - Grant goes to the single valid requester.
  - If both are valid, grant goes to the one not granted last (round-robin via last_grant).
  - The granted requester's ready is asserted combinationally the same cycle. The other ready is low.
  - A transfer is valid && ready. On a transfer:
    - disp_reg ← data.
    - cur_src ← granted index.
    - last_grant ← granted index.
    - hold_cnt ← HOLD_MIN-1.
    - State → HOLD.
- HOLD:
  - Both ready outputs are low and busy = 1.
  - hold_cnt decrements each cycle. When hold_cnt = 0, state → IDLE on the next edge.
- Scan:
  - A prescaler counts 0..SCAN_DIV-1 and wraps.
  - On wrap, digit (3-bit) increments, wrapping 7 → 0.
  - Scan runs continuously in both states, independent of the handshake.
- Decode:
  - nibble = disp_reg[4*digit+3 : 4*digit], so digit 0 shows bits 3:0.
  - The hex glyph is active-low. Examples: 0 → 8'hC0, 1 → 8'hF9, 8 → 8'h80, A → 8'h88.
  - Decimal point (seg[7] = 0) is lit only on digit 0 and only when cur_src = 1.
- Outputs an and seg are registered from (digit, disp_reg, cur_src).
- Reset values:
  - State IDLE, last_grant = 1 (req0 wins the first contention).
  - disp_reg = 0, cur_src = 0, busy = 0.
  - hold_cnt = 0, prescaler = 0, digit = 0.
  - an = 8'hFF, seg = 8'hFF (dark).
- Reset asserted mid-HOLD or mid-scan returns everything to the reset values immediately. No transfer is in progress after release.

## Timing
- ready is combinational from state, last_grant and the valid inputs. data is sampled on the transfer edge.
- An accepted value appears on seg one cycle after the transfer edge (registered output) for the currently selected digit.
- After a transfer, the next transfer can occur no earlier than HOLD_MIN+1 cycles later.
- Digit period is SCAN_DIV cycles; a full frame is 8·SCAN_DIV cycles.
- an/seg change one cycle after a digit increment. an and seg always change on the same edge, so there is no cross-digit ghosting.
- The first post-reset edge loads an = 8'hFE and seg = 8'hC0 (digit 0, value 0).

## Configuration
- SEG_BLANK_LZ_EN defined: leading-zero blanking.
  - Any digit i above the highest nonzero nibble of disp_reg drives seg = 8'hFF.
  - an continues to scan.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- SEG_BLANK_LZ_EN undefined: all eight digits always show their hex glyph.

## Test plan
(All scenarios use SCAN_DIV=4, HOLD_MIN=8.)
1. Reset release, no requests → an=8'hFE, seg=8'hC0 one cycle after release; digit advances every 4 cycles through an=FD, FB … 7F, FE.
2. req0_valid with req0_data=32'h0000_0018 → req0_ready=1 that cycle, busy=1 for 8 cycles. Scan shows digit0 seg=8'h80, digit1 seg=8'hF9, higher digits 8'hC0 (or 8'hFF with SEG_BLANK_LZ_EN).
3. Both valid continuously with distinct data → grants alternate req0, req1, req0 with transfers 9 cycles apart. cur_src toggles. digit0 seg[7]=0 only while cur_src=1.
4. req1_valid asserted during HOLD → req1_ready stays 0 until HOLD ends; accepted the first IDLE cycle.
5. rst asserted 3 cycles into HOLD → an=seg=8'hFF, busy=0, disp_reg=0 immediately. After release, a req1-only request is accepted at once.
6. disp value 32'hAAAA_AAAA → seg=8'h88 on every digit; with SEG_BLANK_LZ_EN, value 0 → only digit 0 shows 8'hC0, others 8'hFF.
